// File: rtl/bf_run_ctrl_if.sv
// Core-side control bundle between the run controller and the brainfuck core.
// master = controller (issues load/clear/run/step), slave = core (reports status).
interface bf_run_ctrl_if;
    logic core_loaded;
    logic core_halted;
    logic core_instr_done;
    logic load_req;
    logic core_clear;
    logic core_run;
    logic core_step;

    modport master (
        input  core_loaded, core_halted, core_instr_done,
        output load_req, core_clear, core_run, core_step
    );

    modport slave (
        output core_loaded, core_halted, core_instr_done,
        input  load_req, core_clear, core_run, core_step
    );
endinterface

// File: rtl/bf_run_ctrl.sv
// Front-panel run controller: debounces load/start/step and sequences the core; optional watchdog via RUN_WATCHDOG_EN.
// Latency: control pulse DB_CYCLES+3 edges after raw press is first sampled; core status -> outputs 1 cycle.
// Backpressure: none; buttons arriving in busy states (LOADING, STEP, ...) are dropped, not queued.
module bf_run_ctrl #(
    parameter int unsigned DB_CYCLES = 65536
`ifdef RUN_WATCHDOG_EN
  , parameter int unsigned WD_CYCLES = 16777216
`endif
) (
    input  logic                CLK,
    input  logic                resetn,
    input  logic                btn_load,
    input  logic                btn_start,
    input  logic                btn_step,
    bf_run_ctrl_if.master       core,
    output logic [2:0]          state_id,
    output logic                wd_timeout
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int B_STEP  = 0;
    localparam int B_START = 1;
    localparam int B_LOAD  = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOADING = 3'd1,
        S_READY   = 3'd2,
        S_RUNNING = 3'd3,
        S_PAUSED  = 3'd4,
        S_STEP    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    logic [2:0]    btn_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    acc;
    logic [2:0]    acc_d;
    logic [2:0]    btn_pls;
    logic [CW-1:0] db_cnt [3];

    state_t state;
    state_t state_nxt;
    logic   clr_nxt, load_nxt, run_nxt, step_nxt;
    logic   clr_q, load_q, run_q, step_q;
    logic   wd_hit;
    logic   wd_to_nxt;

    assign btn_raw = {btn_load, btn_start, btn_step};

    // Accepted level only changes after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
            acc   <= '0;
            acc_d <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            acc_d <= acc;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != acc[i]) begin
                    if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                        acc[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign btn_pls = acc & ~acc_d;

`ifdef RUN_WATCHDOG_EN
    logic [31:0] wd_cnt;
    logic        wd_to_q;

    assign wd_hit     = (state == S_RUNNING) && (wd_cnt >= WD_CYCLES - 1);
    assign wd_timeout = wd_to_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            wd_cnt  <= '0;
            wd_to_q <= 1'b0;
        end else begin
            wd_to_q <= wd_to_nxt;
            if (clr_nxt)
                wd_cnt <= '0;
            else if (run_q)
                wd_cnt <= wd_cnt + 32'd1;
        end
    end
`else
    assign wd_hit     = 1'b0;
    assign wd_timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            clr_q  <= 1'b0;
            load_q <= 1'b0;
            run_q  <= 1'b0;
            step_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            clr_q  <= clr_nxt;
            load_q <= load_nxt;
            run_q  <= run_nxt;
            step_q <= step_nxt;
        end
    end

    // Button priority inside each state: load > start > step.
    always_comb begin
        state_nxt = state;
        clr_nxt   = 1'b0;
        load_nxt  = 1'b0;
        wd_to_nxt = wd_timeout;
        case (state)
            S_IDLE: begin
                if (btn_pls[B_LOAD]) begin
                    clr_nxt   = 1'b1;
                    load_nxt  = 1'b1;
                    state_nxt = S_LOADING;
                end
            end
            S_LOADING: begin
                if (core.core_loaded) state_nxt = S_READY;
            end
            S_READY, S_PAUSED: begin
                if (btn_pls[B_LOAD]) begin
                    clr_nxt   = 1'b1;
                    load_nxt  = 1'b1;
                    state_nxt = S_LOADING;
                end else if (btn_pls[B_START]) begin
                    state_nxt = S_RUNNING;
                end else if (btn_pls[B_STEP]) begin
                    state_nxt = S_STEP;
                end
            end
            S_RUNNING: begin
                if (core.core_halted) begin
                    state_nxt = S_DONE;
                end else if (wd_hit) begin
                    state_nxt = S_DONE;
                    wd_to_nxt = 1'b1;
                end else if (btn_pls[B_START]) begin
                    state_nxt = S_PAUSED;
                end
            end
            S_STEP: begin
                if (core.core_instr_done)
                    state_nxt = core.core_halted ? S_DONE : S_PAUSED;
            end
            S_DONE: begin
                if (btn_pls[B_LOAD]) begin
                    clr_nxt   = 1'b1;
                    load_nxt  = 1'b1;
                    state_nxt = S_LOADING;
                end else if (btn_pls[B_START]) begin
                    clr_nxt   = 1'b1;
                    state_nxt = S_READY;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (clr_nxt) wd_to_nxt = 1'b0;
        run_nxt  = (state_nxt == S_RUNNING);
        step_nxt = (state_nxt == S_STEP) && (state != S_STEP);
    end

    assign core.core_clear = clr_q;
    assign core.load_req   = load_q;
    assign core.core_run   = run_q;
    assign core.core_step  = step_q;
    assign state_id        = state;

endmodule

// File: tb/tb_bf_run_ctrl.sv
// Directed bench for bf_run_ctrl with DB_CYCLES=8 (and WD_CYCLES=100 when RUN_WATCHDOG_EN).
module tb_bf_run_ctrl;

    localparam logic [2:0] P_NONE  = 3'b000;
    localparam logic [2:0] P_STEP  = 3'b001;
    localparam logic [2:0] P_START = 3'b010;
    localparam logic [2:0] P_LOAD  = 3'b100;

    logic       CLK;
    logic       resetn;
    logic       btn_load, btn_start, btn_step;
    logic [2:0] state_id;
    logic       wd_timeout;

    bf_run_ctrl_if cif ();

    bf_run_ctrl #(
        .DB_CYCLES (8)
`ifdef RUN_WATCHDOG_EN
      , .WD_CYCLES (100)
`endif
    ) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .btn_load   (btn_load),
        .btn_start  (btn_start),
        .btn_step   (btn_step),
        .core       (cif),
        .state_id   (state_id),
        .wd_timeout (wd_timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Free-running event counters; the stimulus works with deltas between snapshots.
    int         m_load = 0, m_clr = 0, m_step = 0, m_run = 0, m_paused = 0, m_enter_run = 0;
    logic [2:0] m_prev = 3'd0;

    always @(negedge CLK) begin
        if (cif.load_req)   m_load++;
        if (cif.core_clear) m_clr++;
        if (cif.core_step)  m_step++;
        if (cif.core_run)   m_run++;
        if (state_id == 3'd4) m_paused++;
        if (state_id == 3'd3 && m_prev != 3'd3) m_enter_run++;
        m_prev = state_id;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic hold_btn(input logic [2:0] which, input int n);
        {btn_load, btn_start, btn_step} = which;
        tick(n);
    endtask

    task automatic release_btns();
        {btn_load, btn_start, btn_step} = P_NONE;
        tick(12);
    endtask

    int b_load, b_clr, b_step, b_run, b_paused, b_enter;

    task automatic snap();
        b_load = m_load; b_clr = m_clr; b_step = m_step;
        b_run = m_run; b_paused = m_paused; b_enter = m_enter_run;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0;
        {btn_load, btn_start, btn_step} = P_NONE;
        cif.core_loaded = 1'b0;
        cif.core_halted = 1'b0;
        cif.core_instr_done = 1'b0;
        tick(3);
        check("rst_state", state_id, 0);
        check("rst_outs", {cif.load_req, cif.core_clear, cif.core_run, cif.core_step, wd_timeout}, 0);
        resetn = 1'b1;
        tick(2);

        // IDLE ignores start
        snap();
        hold_btn(P_START, 20);
        release_btns();
        check("idle_start_ignored", state_id, 0);
        check("idle_no_run", m_enter_run - b_enter, 0);

        // Clean load press: pulse lands on the 11th edge
        snap();
        hold_btn(P_LOAD, 10);
        check("load_before_edge11", cif.load_req, 0);
        check("state_before_edge11", state_id, 0);
        hold_btn(P_LOAD, 1);
        check("load_req_edge11", cif.load_req, 1);
        check("clear_edge11", cif.core_clear, 1);
        check("state_loading", state_id, 1);
        hold_btn(P_LOAD, 9);
        check("loading_waits", state_id, 1);
        check("single_load_req", m_load - b_load, 1);
        check("single_clear", m_clr - b_clr, 1);
        cif.core_loaded = 1'b1;
        tick(1);
        check("state_ready", state_id, 2);
        release_btns();
        check("release_no_pulse", m_load - b_load, 1);

        // Bouncing start then a solid hold
        snap();
        for (int k = 0; k < 3; k++) begin
            hold_btn(P_START, 3);
            hold_btn(P_NONE, 3);
        end
        check("bounce_no_run", state_id, 2);
        hold_btn(P_START, 20);
        release_btns();
        check("state_running", state_id, 3);
        check("core_run_high", cif.core_run, 1);
        check("one_enter_run", m_enter_run - b_enter, 1);

`ifdef RUN_WATCHDOG_EN
        for (int i = 0; i < 400 && state_id != 3'd6; i++) tick(1);
        check("wd_state_done", state_id, 6);
        check("wd_run_cycles", m_run - b_run, 100);
        check("wd_timeout_set", wd_timeout, 1);
        check("wd_run_low", cif.core_run, 0);
        hold_btn(P_START, 11);
        check("wd_restart_clear", cif.core_clear, 1);
        check("wd_timeout_clr", wd_timeout, 0);
        check("wd_restart_ready", state_id, 2);
        hold_btn(P_START, 9);
        release_btns();
        hold_btn(P_START, 11);
        check("wd_rerun", state_id, 3);
        hold_btn(P_START, 9);
        release_btns();
`else
        tick(150);
        check("free_run_state", state_id, 3);
        check("free_run_level", cif.core_run, 1);
        check("no_watchdog", wd_timeout, 0);
`endif

        // Halt coincides with a start pulse: halt wins
        snap();
        hold_btn(P_START, 10);
        cif.core_halted = 1'b1;
        hold_btn(P_START, 1);
        check("halt_wins_state", state_id, 6);
        check("halt_run_low", cif.core_run, 0);
        cif.core_halted = 1'b0;
        hold_btn(P_START, 9);
        release_btns();
        check("halt_no_paused", m_paused - b_paused, 0);
        check("done_stays", state_id, 6);

        // DONE + start -> clear, READY
        hold_btn(P_START, 11);
        check("done_start_ready", state_id, 2);
        check("done_start_clear", cif.core_clear, 1);
        check("done_start_noload", cif.load_req, 0);
        hold_btn(P_START, 9);
        release_btns();

        // READY -> RUNNING -> PAUSED
        hold_btn(P_START, 20);
        release_btns();
        hold_btn(P_START, 11);
        check("paused_state", state_id, 4);
        check("paused_run_low", cif.core_run, 0);
        hold_btn(P_START, 9);
        release_btns();

        // Single step, core keeps going
        snap();
        hold_btn(P_STEP, 11);
        check("step_state", state_id, 5);
        check("step_pulse", cif.core_step, 1);
        tick(1);
        check("step_pulse_once", cif.core_step, 0);
        tick(4);
        cif.core_instr_done = 1'b1;
        tick(1);
        cif.core_instr_done = 1'b0;
        check("step_back_paused", state_id, 4);
        hold_btn(P_STEP, 3);
        release_btns();
        check("step_count", m_step - b_step, 1);

        // Single step that halts
        hold_btn(P_STEP, 11);
        check("step2_state", state_id, 5);
        tick(5);
        cif.core_halted = 1'b1;
        cif.core_instr_done = 1'b1;
        tick(1);
        cif.core_halted = 1'b0;
        cif.core_instr_done = 1'b0;
        check("step_halt_done", state_id, 6);
        hold_btn(P_STEP, 3);
        release_btns();
        check("step2_count", m_step - b_step, 2);

        // load beats start from DONE
        snap();
        hold_btn(P_LOAD | P_START, 11);
        check("prio_load_state", state_id, 1);
        check("prio_load_req", cif.load_req, 1);
        hold_btn(P_LOAD | P_START, 1);
        check("prio_then_ready", state_id, 2);
        hold_btn(P_LOAD | P_START, 8);
        release_btns();
        check("prio_one_load", m_load - b_load, 1);

        // start beats step from READY
        hold_btn(P_START | P_STEP, 11);
        check("prio_start_state", state_id, 3);
        check("prio_no_step", cif.core_step, 0);
        hold_btn(P_START | P_STEP, 9);
        release_btns();
        check("prio_still_run", cif.core_run, 1);

        // Asynchronous reset mid-run
        #3;
        resetn = 1'b0;
        #1;
        check("arst_run_low", cif.core_run, 0);
        check("arst_state", state_id, 0);
        tick(2);
        resetn = 1'b1;
        snap();
        tick(30);
        check("post_rst_state", state_id, 0);
        check("post_rst_pulses", (m_load - b_load) + (m_clr - b_clr) + (m_step - b_step), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bf_run_ctrl.md
Name: bf_run_ctrl

Overview:
Front-panel run controller for the brainfuck core. It synchronises and debounces the raw load/start/step buttons and sequences the core through load, run, pause, single-step and done. It sits in top, between the board buttons and the core's control inputs, and replaces the ad-hoc pulse logic there. It also drives state_id for the LEDs and debug prints.

Parameters:
DB_CYCLES, 65536, consecutive stable samples required to accept a button level change (bench uses 8)
WD_CYCLES, 16777216, watchdog limit in core_run cycles (only with RUN_WATCHDOG_EN)

Ports:
CLK  in  1  system clock
resetn  in  1  asynchronous active-low reset
btn_load  in  1  raw load button (BTN3), active-high
btn_start  in  1  raw start/pause button (BTN1), active-high
btn_step  in  1  raw single-step button (BTN2), active-high
core_loaded  in  1  level: program image loaded into core
core_halted  in  1  level: core reached end of program
core_instr_done  in  1  one-cycle pulse: core retired one instruction
load_req  out  1  one-cycle pulse: start program load
core_clear  out  1  one-cycle pulse: reset core iptr/tape, program retained
core_run  out  1  level: core free-runs
core_step  out  1  one-cycle pulse: execute one instruction
state_id  out  3  current FSM state encoding
wd_timeout  out  1  watchdog abort flag

Behaviour:
- Reset: async assert; all outputs 0, state IDLE (0), sync/debounce flops 0, counters 0; core_run drops immediately on reset assert.
- Per button: 2-flop synchroniser -> debouncer: counter increments while sync level != accepted level, clears otherwise; at DB_CYCLES accept new level. Rising edge of accepted level -> 1-cycle internal pulse. Clean press: pulse on the (DB_CYCLES+2)th rising edge after raw first sampled high. Glitches shorter than DB_CYCLES -> no pulse. Release generates no pulse.
- All outputs registered; control pulses asserted the cycle after the triggering button pulse, coincident with the state change.
- States: IDLE=0, LOADING=1, READY=2, RUNNING=3, PAUSED=4, STEP=5, DONE=6.
- IDLE: load -> core_clear+load_req, LOADING. start/step ignored.
- LOADING: core_loaded=1 -> READY. All buttons ignored.
- READY: start -> RUNNING. step -> STEP. load -> clear+load_req, LOADING.
- RUNNING: core_run=1. core_halted -> DONE. Start -> PAUSED. Both same cycle -> DONE (halt wins). load/step ignored.
- PAUSED: core_run=0. start -> RUNNING. step -> STEP. load -> clear+load_req, LOADING.
- STEP: core_step pulsed on entry cycle only. Wait core_instr_done, then core_halted ? DONE : PAUSED. Buttons ignored.
- DONE: core_run=0. start -> core_clear, READY. load -> clear+load_req, LOADING. step ignored.
- Priority when button pulses coincide: load > start > step.
- core_halted already high on entry to RUNNING -> DONE next cycle.
- core_run falls in the same cycle state leaves RUNNING.

Optional Feature:
RUN_WATCHDOG_EN: defined -> 32-bit counter increments each cycle core_run=1 and holds in PAUSED/STEP. Counter clears on core_clear. At WD_CYCLES -> DONE, wd_timeout=1; wd_timeout stays high until next core_clear. Undefined -> no counter, wd_timeout tied 0, and a program that never halts runs indefinitely.

Test Plan:
- Reset then press btn_load 20 cycles (DB_CYCLES=8) -> single load_req and core_clear pulse on the 11th edge after press, state_id=1. Model raises core_loaded -> state_id=2 next cycle.
- Bounce btn_start with 3-cycle high/low pulses, then hold 20 -> exactly one transition READY->RUNNING, core_run=1.
- RUNNING, assert core_halted the same cycle as a start pulse -> state_id=6, core_run=0, no PAUSED.
- PAUSED, press step -> one core_step pulse. core_instr_done 5 cycles later -> state_id=4. Repeat with core_halted=1 -> state_id=6.
- Drop resetn mid-RUNNING -> core_run=0 same timestep, state_id=0, no pulses after release.
- RUN_WATCHDOG_EN, WD_CYCLES=100, core never halts -> DONE after 100 core_run cycles, wd_timeout=1. Start -> core_clear, wd_timeout=0, state_id=2.
